unsigned_seq_div_restoring: RTL and testbench
=============================================

Name: unsigned_seq_div_restoring

Overview:
Unsigned sequential restoring divider, the inverse of the team's 6x6 sequential shift-add multiplier. It takes a 2N-bit dividend, such as a multiplier product, and an N-bit divisor. It produces an N-bit quotient and N-bit remainder, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath and uses the same load-to-start control style, plus a busy/done handshake.

Parameters:
N, 6, operand width; dividend is 2N bits, divisor/quotient/remainder are N bits.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset (0 = reset)
load  in  1  start request; sampled on rising clk
dividend  in  2N  unsigned dividend, sampled when load=1
divisor  in  N  unsigned divisor, sampled when load=1
quotient  out  N  registered quotient
remainder  out  N  registered remainder
busy  out  1  high while iterating
done  out  1  result valid; sticky until next load
ovf  out  1  quotient would not fit in N bits
dbz  out  1  divide by zero

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - all outputs 0; state IDLE; internal registers 0.
  - load is ignored while rst=0.
- States:
  - IDLE: after reset, no result yet.
  - RUN: iterating.
  - DONE: result held.
- load=1 at edge k, in any state (in RUN this aborts and restarts; the old result is lost):
  - capture R (N+1 bits) = {0, dividend[2N-1:N]}, Q = dividend[N-1:0], D = divisor.
  - clear done/ovf/dbz; iteration count = 0.
- Error checks at edge k, with priority dbz over ovf:
  - divisor==0: next state DONE, dbz=1, quotient=all-ones, remainder=dividend[N-1:0]; done rises at edge k+1.
  - dividend[2N-1:N] >= divisor: next state DONE, ovf=1, quotient=all-ones, remainder=dividend[N-1:0]; done rises at edge k+1.
  - busy stays 0 for either error path.
- Otherwise: state RUN, busy=1 from edge k.
- RUN step, each edge:
  - {R,Q} <<= 1.
  - T = R - {0,D} (N+1 bits).
  - If T's MSB=0: R=T, Q[0]=1. Else R unchanged, Q[0]=0.
  - count++.
- Width rule: R < 2D always holds, so N+1 bits suffice and there is no truncation.
- Completion: after N steps (edge k+N), state DONE.
  - quotient=Q, remainder=R[N-1:0], done=1, busy=0.
  - Latency from load edge to done: N cycles (6 at default).
- DONE: outputs hold until the next load or reset. done, ovf and dbz are mutually consistent; ovf and dbz are never both 1.
- quotient/remainder change only on entry to DONE. During RUN they hold the previous result (0 after reset).
- Invariant on a valid result: quotient*divisor + remainder == dividend, with remainder < divisor.

Decomposition:
- Shared package arith_pkg:
  - state enum {IDLE, RUN, DONE}.
  - default width constant N=6.
  - localparam helpers for 2N and N+1 widths, shared with the multiplier.
- Sub-module div_step:
  - combinational single iteration.
  - inputs R, Q, D; outputs next R, next Q.
  - instantiated once; the FSM/counter lives in the top.

Test Plan:
- 100/7: load, dividend=100, divisor=7 -> done at edge k+6, quotient=14, remainder=2, busy high 6 cycles, ovf=dbz=0.
- 3968/63: -> quotient=62, remainder=62 at k+6 (maximum non-overflow upper half).
- dbz: dividend=50, divisor=0 -> dbz=1, done=1 at k+1, quotient=63, remainder=50, busy never 1.
- ovf: dividend=640, divisor=10 (upper half 10 >= 10) -> ovf=1, done at k+1, quotient=63, remainder=0.
- Restart: load 100/7, then at k+3 load 45/4 -> done only at (k+3)+6, quotient=11, remainder=1; no done pulse at k+6.
- Async reset mid-run: load 100/7, drive rst=0 between edges at k+2 -> all outputs 0 immediately (before next edge). After release with no load, state stays IDLE and done=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions: FSM state encoding and operand-width helpers
// used by the sequential multiplier and divider.
package arith_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned NDefault = 6;
  localparam int unsigned NDbl     = 2 * NDefault;
  localparam int unsigned NExt     = NDefault + 1;

  function automatic int unsigned dbl_w(input int unsigned n);
    return 2 * n;
  endfunction

  function automatic int unsigned ext_w(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {R,Q} left, trial-subtract D,
// keep the difference and set the quotient bit when it does not go negative.
module div_step
  import arith_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic [N:0]   i_r,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_d,
  output logic [N:0]   o_r,
  output logic [N-1:0] o_q
);

  logic [N+1:0] w_shift;
  logic [N+1:0] w_diff;
  logic [N-1:0] w_q_sh;

  // One spare bit on top makes the sign of the trial difference unambiguous.
  assign w_shift = {i_r, i_q[N-1]};
  assign w_diff  = w_shift - {2'b00, i_d};
  assign w_q_sh  = {i_q[N-2:0], 1'b0};

  always_comb begin
    o_r = w_shift[N:0];
    o_q = w_q_sh;
    if (!w_diff[N+1]) begin
      o_r = w_diff[N:0];
      o_q = w_q_sh | N'(1);
    end
  end

endmodule

// File: rtl/unsigned_seq_div_restoring.sv
// Unsigned sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, with overflow and divide-by-zero short-circuits.
module unsigned_seq_div_restoring
  import arith_pkg::*;
#(
  parameter int unsigned N = NDefault
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [dbl_w(N)-1:0] dividend,
  input  logic [N-1:0]        divisor,
  output logic [N-1:0]        quotient,
  output logic [N-1:0]        remainder,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic                dbz
);

  localparam int unsigned WDbl = dbl_w(N);
  localparam int unsigned WExt = ext_w(N);
  localparam int unsigned CW   = $clog2(N + 1);

  state_e          r_state;
  logic [WExt-1:0] r_r;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_d;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_quot;
  logic [N-1:0]    r_rem;
  logic            r_busy;
  logic            r_done;
  logic            r_ovf;
  logic            r_dbz;

  logic [WExt-1:0] w_r_nxt;
  logic [N-1:0]    w_q_nxt;

  div_step #(
    .N (N)
  ) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_r     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (load) begin
      r_r    <= {1'b0, dividend[WDbl-1:N]};
      r_q    <= dividend[N-1:0];
      r_d    <= divisor;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_dbz  <= 1'b0;
      if ((divisor == '0) || (dividend[WDbl-1:N] >= divisor)) begin
        r_state <= StDone;
        r_busy  <= 1'b0;
      end else begin
        r_state <= StRun;
        r_busy  <= 1'b1;
      end
    end else begin
      case (r_state)
        StRun: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state <= StDone;
            r_quot  <= w_q_nxt;
            r_rem   <= w_r_nxt[N-1:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        StDone: begin
          // DONE with done still low means an error short-circuit awaiting commit.
          if (!r_done) begin
            r_done <= 1'b1;
            r_quot <= '1;
            r_rem  <= r_q;
            r_dbz  <= (r_d == '0);
            r_ovf  <= (r_d != '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_unsigned_seq_div_restoring.sv
// Self-checking bench for unsigned_seq_div_restoring: directed cases plus random operands
// checked against a plain-arithmetic division model.
module tb_unsigned_seq_div_restoring;

  localparam int unsigned N = 6;

  logic           clk;
  logic           rst;
  logic           load;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           dbz;

  int checks   = 0;
  int failures = 0;
  int prev_q   = 0;

  unsigned_seq_div_restoring #(
    .N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Loads one operation and follows it to done, comparing against ordinary / and %.
  task automatic run_op(input string tag, input int a, input int b);
    int exp_q, exp_r, exp_lat, exp_busy, lat, busy_cnt;
    bit exp_ovf, exp_dbz;
    exp_dbz = (b == 0);
    exp_ovf = !exp_dbz && ((a / 64) >= b);
    if (exp_dbz || exp_ovf) begin
      exp_q = 63; exp_r = a % 64; exp_lat = 1; exp_busy = 0;
    end else begin
      exp_q = a / b; exp_r = a % b; exp_lat = N; exp_busy = N;
    end
    @(negedge clk);
    load = 1'b1; dividend = (2*N)'(a); divisor = N'(b);
    @(posedge clk); #1;
    load = 1'b0;
    chk({tag, ":done_clr"}, int'(done), 0);
    if (exp_busy != 0) chk({tag, ":q_hold"}, int'(quotient), prev_q);
    busy_cnt = int'(busy);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
    end
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":quot"}, int'(quotient), exp_q);
    chk({tag, ":rem"}, int'(remainder), exp_r);
    chk({tag, ":ovf"}, int'(ovf), int'(exp_ovf));
    chk({tag, ":dbz"}, int'(dbz), int'(exp_dbz));
    chk({tag, ":busy_cycles"}, busy_cnt, exp_busy);
    prev_q = exp_q;
  endtask

  initial begin
    int lat;
    int b;
    int a;
    rst = 1'b0; load = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    // load must be ignored while reset is asserted
    @(negedge clk); load = 1'b1; dividend = 12'd100; divisor = 6'd7;
    @(posedge clk); #1;
    chk("rst:busy", int'(busy), 0);
    chk("rst:done", int'(done), 0);
    chk("rst:quot", int'(quotient), 0);
    chk("rst:rem", int'(remainder), 0);
    chk("rst:flags", int'({ovf, dbz}), 0);
    @(negedge clk); load = 1'b0; rst = 1'b1;

    run_op("100/7", 100, 7);
    run_op("3968/63", 3968, 63);
    run_op("dbz50", 50, 0);
    run_op("ovf640/10", 640, 10);
    run_op("0/1", 0, 1);
    run_op("4095/63_ovf", 4095, 63);

    for (int i = 0; i < 24; i++) begin
      b = int'($urandom_range(0, 63));
      if (i % 4 == 3) a = int'($urandom_range(0, 4095));
      else if (b == 0) a = int'($urandom_range(0, 4095));
      else a = int'($urandom_range(0, b * 64 - 1));
      run_op($sformatf("rnd%0d", i), a, b);
    end

    // Restart mid-run: the second load must fully replace the first.
    @(negedge clk); load = 1'b1; dividend = 12'd100; divisor = 6'd7;
    @(posedge clk); #1; load = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); load = 1'b1; dividend = 12'd45; divisor = 6'd4;
    @(posedge clk); #1; load = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("restart:latency", lat, N);
    chk("restart:quot", int'(quotient), 11);
    chk("restart:rem", int'(remainder), 1);

    // Asynchronous reset between edges must clear outputs immediately.
    @(negedge clk); load = 1'b1; dividend = 12'd100; divisor = 6'd7;
    @(posedge clk); #1; load = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst:busy", int'(busy), 0);
    chk("arst:done", int'(done), 0);
    chk("arst:quot", int'(quotient), 0);
    chk("arst:rem", int'(remainder), 0);
    #2 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("arst:idle_done", int'(done), 0);
    chk("arst:idle_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
